seg7_reader: RTL and testbench

// - Reverse of the 7-segment encoder: samples a 7-bit segment bus (segment 1 in bit 0 .. segment 7 in bit 6, active-high), resynchronises it, filters glitches, decodes it back to a 4-bit digit.
// - Each new stable digit goes out on a valid/ready port; illegal patterns raise an error strobe.
// - Used as a loopback checker on the display pins and as a front end for segment-driven inputs.

---
 rtl/seg7_reader.sv | 214 +++++++++++++++++++++
 tb/tb_seg7_reader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_reader.sv
// seg7_reader: resynchronises and glitch-filters a 7-segment bus,
// decodes it to a digit and offers it on a valid/ready port.
//
// Ports:
//   clk, rst_n       rising-edge clock, async active-low reset
//   seg_in[6:0]      raw segment bus (seg 1 = bit 0), async to clk
//   out_ready        consumer accepts digit_out this cycle
//   out_valid        digit_out holds an unconsumed digit
//   digit_out[3:0]   decoded digit 0..9
//   blank            level, last accepted pattern was 7'h00
//   err              1-cycle pulse, illegal stable pattern
//   overrun          1-cycle pulse, unconsumed digit overwritten
//   err_count[7:0]   saturating err counter, present only when
//                    SEG7_READER_ERRCNT_EN is defined
//
// Parameters: SYNC_STAGES (>=2), STABLE_CYCLES (>=1).
module seg7_reader #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] seg_in,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [3:0] digit_out,
   output logic       blank,
   output logic       err,
   output logic       overrun
`ifdef SEG7_READER_ERRCNT_EN
   ,
   output logic [7:0] err_count
`endif
);

   // One extra bit so the run length can reach STABLE_CYCLES+1
   // without wrapping while the filter is locked.
   localparam int CW = $clog2(STABLE_CYCLES + 1) + 1;
   localparam logic [CW-1:0] STABLE_N = CW'(STABLE_CYCLES);

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } state_t;

   // ------------------------------------------------------------
   // Pattern decode: {legal, digit}
   // ------------------------------------------------------------
   function automatic logic [4:0] decode(input logic [6:0] p);
      logic [4:0] r;
      r = 5'h00;
      unique case (p)
         7'h3F:   r = 5'h10;
         7'h06:   r = 5'h11;
         7'h5B:   r = 5'h12;
         7'h4F:   r = 5'h13;
         7'h66:   r = 5'h14;
         7'h6D:   r = 5'h15;
         7'h7C:   r = 5'h16;
         7'h07:   r = 5'h17;
         7'h7F:   r = 5'h18;
         7'h67:   r = 5'h19;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   // ------------------------------------------------------------
   // State
   // ------------------------------------------------------------
   logic [6:0]    sync_q [SYNC_STAGES];
   logic [6:0]    prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   state_t        state_q, state_d;
   logic [6:0]    last_q, last_d;
   logic          valid_q, valid_d;
   logic [3:0]    digit_q, digit_d;
   logic          blank_q, blank_d;
   logic          err_q, err_d;
   logic          ovr_q, ovr_d;

   // ------------------------------------------------------------
   // Stability filter
   // ------------------------------------------------------------
   logic [6:0]    s;
   logic          same;
   logic [CW-1:0] run;
   logic          accept;
   logic          fresh;
   logic [4:0]    dec;
   logic          ev_digit;
   logic          ev_blank;
   logic          ev_ill;
   logic          xfer;

   assign s    = sync_q[SYNC_STAGES-1];
   assign same = (s == prev_q);

   // run = number of consecutive identical samples including s
   assign run   = same ? cnt_q + CW'(1) : CW'(1);
   assign cnt_d = (run > STABLE_N) ? STABLE_N : run;

   // A change of s while locked restarts the count; with
   // STABLE_CYCLES=1 that same sample is already accepted.
   assign accept = (run == STABLE_N) &&
                   ((state_q == UNLOCKED) || !same);

   // Re-accepting the last pattern after a glitch is silent.
   assign fresh  = accept && (s != last_q);
   assign last_d = accept ? s : last_q;

   assign dec      = decode(s);
   assign ev_digit = fresh && dec[4];
   assign ev_blank = fresh && (s == 7'h00);
   assign ev_ill   = fresh && !dec[4] && (s != 7'h00);
   assign xfer     = valid_q && out_ready;

   // ------------------------------------------------------------
   // FSM next state
   // ------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         UNLOCKED: begin
            if (accept) state_d = LOCKED;
         end
         LOCKED: begin
            if (!same) state_d = accept ? LOCKED : UNLOCKED;
         end
         default: state_d = UNLOCKED;
      endcase
   end

   // ------------------------------------------------------------
   // Output port next state
   // ------------------------------------------------------------
   always_comb begin
      valid_d = valid_q;
      digit_d = digit_q;
      blank_d = blank_q;
      err_d   = ev_ill;
      ovr_d   = 1'b0;
      if (ev_digit) begin
         // A transfer on this edge frees the slot: no overrun.
         ovr_d   = valid_q && !out_ready;
         valid_d = 1'b1;
         digit_d = dec[3:0];
         blank_d = 1'b0;
      end else if (xfer) begin
         valid_d = 1'b0;
      end
      if (ev_blank) blank_d = 1'b1;
   end

   // ------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= 7'h00;
         end
         prev_q  <= 7'h00;
         cnt_q   <= '0;
         state_q <= UNLOCKED;
         last_q  <= 7'h00;
         valid_q <= 1'b0;
         digit_q <= 4'h0;
         blank_q <= 1'b1;
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         sync_q[0] <= seg_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q  <= s;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         digit_q <= digit_d;
         blank_q <= blank_d;
         err_q   <= err_d;
         ovr_q   <= ovr_d;
      end
   end

   assign out_valid = valid_q;
   assign digit_out = digit_q;
   assign blank     = blank_q;
   assign err       = err_q;
   assign overrun   = ovr_q;

`ifdef SEG7_READER_ERRCNT_EN
   // ------------------------------------------------------------
   // Saturating error counter, cleared only by reset
   // ------------------------------------------------------------
   logic [7:0] ecnt_q, ecnt_d;

   always_comb begin
      ecnt_d = ecnt_q;
      if (ev_ill && (ecnt_q != 8'hFF)) ecnt_d = ecnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ecnt_q <= 8'h00;
      else        ecnt_q <= ecnt_d;
   end

   assign err_count = ecnt_q;
`endif

endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: randomized and directed checks of seg7_reader
// against a run-length reference model of the segment stream.
module tb_seg7_reader;

   localparam int SYNC = 2;
   localparam int STAB = 4;

   logic       clk;
   logic       rst_n;
   logic [6:0] seg_in;
   logic       out_ready;
   logic       out_valid;
   logic [3:0] digit_out;
   logic       blank;
   logic       err;
   logic       overrun;
`ifdef SEG7_READER_ERRCNT_EN
   logic [7:0] err_count;
`endif

   seg7_reader #(
      .SYNC_STAGES  (SYNC),
      .STABLE_CYCLES(STAB)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .seg_in   (seg_in),
      .out_ready(out_ready),
      .out_valid(out_valid),
      .digit_out(digit_out),
      .blank    (blank),
      .err      (err),
      .overrun  (overrun)
`ifdef SEG7_READER_ERRCNT_EN
      ,
      .err_count(err_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------
   // Reference model: the sample seen by the filter is seg_in
   // delayed by SYNC edges; an event fires when that sample has
   // been constant for exactly STAB edges and differs from the
   // last accepted pattern.
   // ------------------------------------------------------------
   logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
                               7'h66, 7'h6D, 7'h7C, 7'h07,
                               7'h7F, 7'h67};
   logic [6:0] m_pipe [SYNC];
   logic [6:0] m_prev;
   logic [6:0] m_last;
   int         m_run;
   logic       exp_valid;
   logic [3:0] exp_digit;
   logic       exp_blank;
   logic       exp_err;
   logic       exp_ovr;
   int         exp_ecnt;

   function automatic int lookup(input logic [6:0] p);
      for (int i = 0; i < 10; i++) begin
         if (seg_tab[i] == p) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < SYNC; i++) m_pipe[i] = 7'h00;
      m_prev    = 7'h00;
      m_last    = 7'h00;
      m_run     = 0;
      exp_valid = 1'b0;
      exp_digit = 4'h0;
      exp_blank = 1'b1;
      exp_err   = 1'b0;
      exp_ovr   = 1'b0;
      exp_ecnt  = 0;
   endtask

   task automatic model_edge(input logic [6:0] seg, input logic rdy);
      logic [6:0] smp;
      logic       xf;
      logic       dig_ev;
      int         idx;
      smp = m_pipe[SYNC-1];
      m_run = (smp == m_prev) ? m_run + 1 : 1;
      m_prev = smp;
      for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = seg;
      xf = exp_valid && rdy;
      exp_err = 1'b0;
      exp_ovr = 1'b0;
      dig_ev = 1'b0;
      if (m_run == STAB && smp != m_last) begin
         m_last = smp;
         idx = lookup(smp);
         if (idx >= 0) begin
            dig_ev    = 1'b1;
            exp_ovr   = exp_valid && !rdy;
            exp_valid = 1'b1;
            exp_digit = 4'(idx);
            exp_blank = 1'b0;
         end else if (smp == 7'h00) begin
            exp_blank = 1'b1;
         end else begin
            exp_err = 1'b1;
            if (exp_ecnt < 255) exp_ecnt++;
         end
      end
      if (!dig_ev && xf) exp_valid = 1'b0;
   endtask

   // ------------------------------------------------------------
   // Compare process: every cycle, away from the active edge
   // ------------------------------------------------------------
   always @(negedge clk) begin
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("digit_out", 32'(digit_out), 32'(exp_digit));
      chk("blank",     32'(blank),     32'(exp_blank));
      chk("err",       32'(err),       32'(exp_err));
      chk("overrun",   32'(overrun),   32'(exp_ovr));
`ifdef SEG7_READER_ERRCNT_EN
      chk("err_count", 32'(err_count), 32'(exp_ecnt));
`endif
   end

   // ------------------------------------------------------------
   // Stimulus helpers and observation tallies
   // ------------------------------------------------------------
   int n_err;
   int n_ovr;
   int n_xfer [16];

   task automatic clr_obs();
      n_err = 0;
      n_ovr = 0;
      for (int i = 0; i < 16; i++) n_xfer[i] = 0;
   endtask

   // Inputs change on the falling edge; one rising edge per call.
   task automatic step(input logic [6:0] seg, input logic rdy);
      seg_in    = seg;
      out_ready = rdy;
      if (out_valid && rdy) n_xfer[digit_out]++;
      @(posedge clk);
      model_edge(seg, rdy);
      @(negedge clk);
      n_err += int'(err);
      n_ovr += int'(overrun);
   endtask

   task automatic hold(input logic [6:0] seg, input logic rdy,
                       input int n);
      for (int i = 0; i < n; i++) step(seg, rdy);
   endtask

   int k;

   initial begin
      rst_n     = 1'b0;
      seg_in    = 7'h00;
      out_ready = 1'b0;
      model_reset();
      clr_obs();
      repeat (3) @(negedge clk);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst blank",     32'(blank),     32'd1);
      chk("rst digit_out", 32'(digit_out), 32'd0);
      chk("rst err",       32'(err),       32'd0);
      rst_n = 1'b1;
      hold(7'h00, 1'b0, 8);

      // Latency: change to 5B shows out_valid 6 edges later.
      k = 0;
      while (!out_valid && k < 20) begin
         step(7'h5B, 1'b0);
         k++;
      end
      chk("latency", 32'(k), 32'd6);
      chk("lat digit", 32'(digit_out), 32'd2);
      chk("lat blank", 32'(blank), 32'd0);
      hold(7'h5B, 1'b0, 10);
      chk("held valid", 32'(out_valid), 32'd1);

      // One transfer of digit 1, nothing more while held.
      clr_obs();
      hold(7'h06, 1'b1, 60);
      chk("xfer1 count", 32'(n_xfer[1]), 32'd1);
      chk("xfer1 drained", 32'(out_valid), 32'd0);

      // Short 66 glitch inside a stable 4F is filtered.
      clr_obs();
      hold(7'h4F, 1'b0, 10);
      hold(7'h66, 1'b0, 3);
      hold(7'h4F, 1'b0, 20);
      chk("glitch ovr", 32'(n_ovr), 32'd0);
      chk("glitch err", 32'(n_err), 32'd0);
      chk("glitch digit", 32'(digit_out), 32'd3);

      // Overwrite of an unconsumed digit.
      step(7'h4F, 1'b1);
      clr_obs();
      hold(7'h6D, 1'b0, 10);
      chk("ovr first", 32'(digit_out), 32'd5);
      hold(7'h7F, 1'b0, 10);
      chk("ovr count", 32'(n_ovr), 32'd1);
      chk("ovr digit", 32'(digit_out), 32'd8);
      chk("ovr valid", 32'(out_valid), 32'd1);

      // Illegal pattern.
      clr_obs();
      hold(7'h49, 1'b0, 10);
      chk("ill err", 32'(n_err), 32'd1);
      chk("ill valid", 32'(out_valid), 32'd1);
      chk("ill blank", 32'(blank), 32'd0);
`ifdef SEG7_READER_ERRCNT_EN
      chk("ill err_count", 32'(err_count), 32'd1);
`endif

      // 7, blank, 7 gives two digit-7 events.
      clr_obs();
      hold(7'h07, 1'b1, 10);
      hold(7'h00, 1'b1, 10);
      chk("blank between", 32'(blank), 32'd1);
      hold(7'h07, 1'b1, 10);
      chk("two sevens", 32'(n_xfer[7]), 32'd2);

      // Randomized patterns, hold times and back-pressure.
      for (int ep = 0; ep < 600; ep++) begin
         logic [6:0] p;
         int r;
         int len;
         r = $urandom_range(0, 15);
         if (r < 10)       p = seg_tab[r];
         else if (r == 10) p = 7'h00;
         else if (r == 11) p = 7'h49;
         else if (r == 12) p = 7'h7E;
         else if (r == 13) p = 7'h01;
         else              p = 7'($urandom);
         len = $urandom_range(1, 9);
         for (int c = 0; c < len; c++) begin
            step(p, 1'($urandom_range(0, 2) != 0));
         end
      end

`ifdef SEG7_READER_ERRCNT_EN
      // Saturation of the error counter.
      for (int ep = 0; ep < 300; ep++) begin
         hold(7'h49, 1'($urandom), 7);
         hold(7'h00, 1'($urandom), 7);
      end
      chk("err_count sat", 32'(err_count), 32'hFF);
`endif

      // Asynchronous reset in the middle of a count.
      hold(7'h00, 1'b1, 10);
      hold(7'h3F, 1'b0, 3);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async valid", 32'(out_valid), 32'd0);
      chk("async blank", 32'(blank), 32'd1);
      chk("async digit", 32'(digit_out), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      hold(7'h3F, 1'b0, 10);
      chk("post-reset digit", 32'(digit_out), 32'd0);
      chk("post-reset valid", 32'(out_valid), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
